mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM for the RV32I datapath: IF/ID/EX/MEM/WB sequencing.

---
 rtl/mc_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multi-cycle control FSM for an RV32I datapath. Sequences
//            IF/ID/EX/MEM/WB, decodes the IR opcode into an instruction
//            class plus immediate format, and drives the datapath strobes
//            and mux selects. Handshakes with instruction and data memory
//            through mem_ready, with a bounded wait that raises a sticky
//            bus error on timeout or on an illegal opcode.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            inst[31:0]        - IR contents (opcode sampled in ID)
//            mem_ready         - memory access complete (pulse or level)
//            br_taken          - branch comparison result (used in EX)
//            halt_req          - park the core between instructions
//            state[2:0]        - IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5 ERR=7
//            imem_re, ir_we, dmem_re, dmem_we, reg_we, pc_we - strobes
//            sext_op[2:0]      - immediate format (I=0 S=1 B=2 U=3 J=4)
//            alu_b_sel         - 0=rs2, 1=immediate
//            wb_sel[1:0]       - 0=ALU, 1=mem, 2=PC+4, 3=imm
//            npc_sel[1:0]      - 0=PC+4, 1=PC+imm, 2=ALU&~1
//            bus_err           - sticky timeout / illegal opcode flag
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        br_taken,
    input  logic        halt_req,
    output logic [2:0]  state,
    output logic        imem_re,
    output logic        ir_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [2:0]  sext_op,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  npc_sel,
    output logic        bus_err
);

    // Immediate format codes shared with the immediate extender.
    localparam logic [2:0] c_SEXT_I = 3'd0;
    localparam logic [2:0] c_SEXT_S = 3'd1;
    localparam logic [2:0] c_SEXT_B = 3'd2;
    localparam logic [2:0] c_SEXT_U = 3'd3;
    localparam logic [2:0] c_SEXT_J = 3'd4;

    // Last counter value before the timeout fires; a memory access that is
    // still pending in this cycle without mem_ready sends the FSM to ERR.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R      = 4'd0,
        C_IALU   = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_JAL    = 4'd5,
        C_JALR   = 4'd6,
        C_LUI    = 4'd7,
        C_AUIPC  = 4'd8
    } class_t;

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    logic [2:0]       r_sext;
    logic [CNT_W-1:0] r_cnt;

    class_t     w_dec_class;
    logic [2:0] w_dec_sext;
    logic       w_dec_legal;

    logic w_imem_re, w_ir_we, w_dmem_re, w_dmem_we, w_reg_we, w_pc_we;
    logic [1:0] w_npc_sel;
    logic       w_mem_wait;

    // Only the opcode field steers control; the rest of the IR feeds the
    // datapath directly.
    logic w_unused_inst_hi;
    assign w_unused_inst_hi = ^inst[31:7];

    // ------------------------------------------------------------------
    // Opcode decode (consumed only while in ID)
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_class = C_IALU;
        w_dec_sext  = c_SEXT_I;
        w_dec_legal = 1'b1;
        case (inst[6:0])
            7'b0110011: begin w_dec_class = C_R;      w_dec_sext = c_SEXT_I; end
            7'b0010011: begin w_dec_class = C_IALU;   w_dec_sext = c_SEXT_I; end
            7'b0000011: begin w_dec_class = C_LOAD;   w_dec_sext = c_SEXT_I; end
            7'b0100011: begin w_dec_class = C_STORE;  w_dec_sext = c_SEXT_S; end
            7'b1100011: begin w_dec_class = C_BRANCH; w_dec_sext = c_SEXT_B; end
            7'b1101111: begin w_dec_class = C_JAL;    w_dec_sext = c_SEXT_J; end
            7'b1100111: begin w_dec_class = C_JALR;   w_dec_sext = c_SEXT_I; end
            7'b0110111: begin w_dec_class = C_LUI;    w_dec_sext = c_SEXT_U; end
            7'b0010111: begin w_dec_class = C_AUIPC;  w_dec_sext = c_SEXT_U; end
            default:    w_dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State, class, immediate format and wait counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
            r_class <= C_IALU;
            r_sext  <= c_SEXT_I;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID && w_dec_legal) begin
                r_class <= w_dec_class;
                r_sext  <= w_dec_sext;
            end
            // Any state change clears the counter, so it is zero on the
            // first cycle of every IF/MEM visit; it only advances while an
            // access stays pending.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_mem_wait && !mem_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_mem_wait = (r_state == S_IF) || (r_state == S_MEM);

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_imem_re = 1'b0;
        w_ir_we   = 1'b0;
        w_dmem_re = 1'b0;
        w_dmem_we = 1'b0;
        w_reg_we  = 1'b0;
        w_pc_we   = 1'b0;
        w_npc_sel = 2'd0;
        case (r_state)
            S_IF: begin
                // A zero counter marks the first IF cycle: a pending halt
                // request parks the core before any fetch is issued.
                if (r_cnt == '0 && halt_req) begin
                    w_next = S_HALT;
                end else begin
                    w_imem_re = 1'b1;
                    if (mem_ready) begin
                        w_ir_we = 1'b1;
                        w_next  = S_ID;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_next = S_ERR;
                    end
                end
            end
            S_ID: begin
                w_next = w_dec_legal ? S_EX : S_ERR;
            end
            S_EX: begin
                case (r_class)
                    C_BRANCH: begin
                        w_pc_we   = 1'b1;
                        w_npc_sel = br_taken ? 2'd1 : 2'd0;
                        w_next    = S_IF;
                    end
                    C_LOAD, C_STORE: w_next = S_MEM;
                    default:         w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_dmem_re = (r_class == C_LOAD);
                w_dmem_we = (r_class == C_STORE);
                if (mem_ready) begin
                    if (r_class == C_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_we = 1'b1;
                        w_next  = S_IF;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                case (r_class)
                    C_JAL:   w_npc_sel = 2'd1;
                    C_JALR:  w_npc_sel = 2'd2;
                    default: w_npc_sel = 2'd0;
                endcase
                w_next = S_IF;
            end
            S_HALT: begin
                if (!halt_req) begin
                    w_next = S_IF;
                end
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Class-driven datapath selects
    // ------------------------------------------------------------------
    always_comb begin
        alu_b_sel = 1'b0;
        wb_sel    = 2'd0;
        case (r_class)
            C_IALU:  alu_b_sel = 1'b1;
            C_LOAD:  begin alu_b_sel = 1'b1; wb_sel = 2'd1; end
            C_STORE: alu_b_sel = 1'b1;
            C_JAL:   wb_sel = 2'd2;
            C_JALR:  begin alu_b_sel = 1'b1; wb_sel = 2'd2; end
            C_LUI:   wb_sel = 2'd3;
            C_AUIPC: alu_b_sel = 1'b1;
            default: begin alu_b_sel = 1'b0; wb_sel = 2'd0; end
        endcase
    end

    // Strobes are masked by rst directly so an in-flight access is dropped
    // the moment reset asserts, independent of the clock.
    assign imem_re = w_imem_re & ~rst;
    assign ir_we   = w_ir_we   & ~rst;
    assign dmem_re = w_dmem_re & ~rst;
    assign dmem_we = w_dmem_we & ~rst;
    assign reg_we  = w_reg_we  & ~rst;
    assign pc_we   = w_pc_we   & ~rst;

    assign npc_sel = w_npc_sel;
    assign sext_op = r_sext;
    assign state   = r_state;
    // ERR is only left through reset, so the state itself is the sticky flag.
    assign bus_err = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Directed self-checking bench for mc_ctrl_fsm. Inputs change just
//            after the falling edge; outputs are sampled 1 ns later.
//            Strobes are compared as {imem_re,ir_we,dmem_re,dmem_we,reg_we,pc_we}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam logic [2:0] c_ST_IF   = 3'd0;
    localparam logic [2:0] c_ST_ID   = 3'd1;
    localparam logic [2:0] c_ST_EX   = 3'd2;
    localparam logic [2:0] c_ST_MEM  = 3'd3;
    localparam logic [2:0] c_ST_WB   = 3'd4;
    localparam logic [2:0] c_ST_HALT = 3'd5;
    localparam logic [2:0] c_ST_ERR  = 3'd7;

    localparam logic [5:0] c_SB_NONE  = 6'b000000;
    localparam logic [5:0] c_SB_FETCH = 6'b100000;
    localparam logic [5:0] c_SB_FLOAD = 6'b110000;
    localparam logic [5:0] c_SB_RD    = 6'b001000;
    localparam logic [5:0] c_SB_WR    = 6'b000100;
    localparam logic [5:0] c_SB_WRPC  = 6'b000101;
    localparam logic [5:0] c_SB_WB    = 6'b000011;
    localparam logic [5:0] c_SB_PC    = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        br_taken;
    logic        halt_req;
    logic [2:0]  state;
    logic        imem_re, ir_we, dmem_re, dmem_we, reg_we, pc_we;
    logic [2:0]  sext_op;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic [1:0]  npc_sel;
    logic        bus_err;
    logic [5:0]  strobes;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign strobes = {imem_re, ir_we, dmem_re, dmem_we, reg_we, pc_we};

    mc_ctrl_fsm #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .halt_req  (halt_req),
        .state     (state),
        .imem_re   (imem_re),
        .ir_we     (ir_we),
        .dmem_re   (dmem_re),
        .dmem_we   (dmem_we),
        .reg_we    (reg_we),
        .pc_we     (pc_we),
        .sext_op   (sext_op),
        .alu_b_sel (alu_b_sel),
        .wb_sel    (wb_sel),
        .npc_sel   (npc_sel),
        .bus_err   (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sample state and strobes for the current cycle (no clock advance).
    task automatic look(input string tag, input logic [2:0] st, input logic [5:0] sb);
        #1;
        chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
        chk({tag, ".strobes"}, {26'd0, strobes}, {26'd0, sb});
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    // Instruction that retires through WB, zero-wait fetch.
    task automatic run_wb(input string tag, input logic [31:0] iw, input logic [2:0] sx,
                          input logic ab, input logic [1:0] wb, input logic [1:0] np);
        inst = iw; mem_ready = 1'b1;
        look({tag, ".if"}, c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look({tag, ".id"}, c_ST_ID, c_SB_NONE); adv();
        look({tag, ".ex"}, c_ST_EX, c_SB_NONE);
        chk({tag, ".sext"}, {29'd0, sext_op}, {29'd0, sx});
        chk({tag, ".alu_b"}, {31'd0, alu_b_sel}, {31'd0, ab});
        adv();
        look({tag, ".wb"}, c_ST_WB, c_SB_WB);
        chk({tag, ".wb_sel"}, {30'd0, wb_sel}, {30'd0, wb});
        chk({tag, ".npc"}, {30'd0, npc_sel}, {30'd0, np});
        adv();
    endtask

    task automatic run_branch(input string tag, input logic taken, input logic [1:0] np);
        inst = 32'h0020_8463; mem_ready = 1'b1; br_taken = taken;
        look({tag, ".if"}, c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look({tag, ".id"}, c_ST_ID, c_SB_NONE); adv();
        look({tag, ".ex"}, c_ST_EX, c_SB_PC);
        chk({tag, ".npc"}, {30'd0, npc_sel}, {30'd0, np});
        chk({tag, ".sext"}, {29'd0, sext_op}, 32'd2);
        adv();
        br_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst = 32'h0; mem_ready = 1'b0; br_taken = 1'b0; halt_req = 1'b0;
        adv(); adv();
        look("rst", c_ST_IF, c_SB_NONE);
        chk("rst.bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst.sext", {29'd0, sext_op}, 32'd0);
        adv();
        rst = 1'b0;

        // Instructions retiring through WB: inst, sext, alu_b, wb_sel, npc_sel
        run_wb("addi",  32'h0050_0093, 3'd0, 1'b1, 2'd0, 2'd0);
        run_wb("add",   32'h0020_81B3, 3'd0, 1'b0, 2'd0, 2'd0);
        run_wb("jal",   32'h0000_006F, 3'd4, 1'b0, 2'd2, 2'd1);
        run_wb("jalr",  32'h0000_8067, 3'd0, 1'b1, 2'd2, 2'd2);
        run_wb("lui",   32'h0000_00B7, 3'd3, 1'b0, 2'd3, 2'd0);
        run_wb("auipc", 32'h0000_0097, 3'd3, 1'b1, 2'd0, 2'd0);

        run_branch("beq_t",  1'b1, 2'd1);
        run_branch("beq_nt", 1'b0, 2'd0);

        // Load with three wait cycles: dmem_re held four cycles
        inst = 32'h0000_A103; mem_ready = 1'b1;
        look("lw.if", c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look("lw.id", c_ST_ID, c_SB_NONE); adv();
        look("lw.ex", c_ST_EX, c_SB_NONE); adv();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            look("lw.mem", c_ST_MEM, c_SB_RD); adv();
        end
        mem_ready = 1'b0;
        look("lw.wb", c_ST_WB, c_SB_WB);
        chk("lw.wb_sel", {30'd0, wb_sel}, 32'd1);
        adv();

        // Store, zero-wait
        inst = 32'h0020_A023; mem_ready = 1'b1;
        look("sw.if", c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look("sw.id", c_ST_ID, c_SB_NONE); adv();
        look("sw.ex", c_ST_EX, c_SB_NONE);
        chk("sw.sext", {29'd0, sext_op}, 32'd1);
        adv();
        mem_ready = 1'b1;
        look("sw.mem", c_ST_MEM, c_SB_WRPC);
        chk("sw.npc", {30'd0, npc_sel}, 32'd0);
        adv();

        // Halt requested on IF entry: no fetch, park, then resume
        mem_ready = 1'b0; halt_req = 1'b1;
        look("halt.if", c_ST_IF, c_SB_NONE); adv();
        look("halt.park", c_ST_HALT, c_SB_NONE); adv();
        halt_req = 1'b0;
        look("halt.rel", c_ST_HALT, c_SB_NONE); adv();

        // mem_ready on the 16th IF cycle still completes the fetch
        inst = 32'h0050_0093;
        for (int i = 0; i < 15; i++) begin
            look("tmo_edge.wait", c_ST_IF, c_SB_FETCH); adv();
        end
        mem_ready = 1'b1;
        look("tmo_edge.ready", c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look("tmo_edge.id", c_ST_ID, c_SB_NONE); adv();
        look("tmo_edge.ex", c_ST_EX, c_SB_NONE); adv();
        look("tmo_edge.wb", c_ST_WB, c_SB_WB); adv();

        // No mem_ready for 16 IF cycles -> ERR
        for (int i = 0; i < 16; i++) begin
            look("tmo.wait", c_ST_IF, c_SB_FETCH); adv();
        end
        mem_ready = 1'b1;
        look("tmo.err", c_ST_ERR, c_SB_NONE);
        chk("tmo.bus_err", {31'd0, bus_err}, 32'd1);
        adv();
        look("tmo.sticky", c_ST_ERR, c_SB_NONE);
        adv();

        // Reset mid-MEM drops dmem_we immediately
        mem_ready = 1'b0; rst = 1'b1;
        look("rst2", c_ST_IF, c_SB_NONE);
        chk("rst2.bus_err", {31'd0, bus_err}, 32'd0);
        adv();
        rst = 1'b0;
        inst = 32'h0020_A023; mem_ready = 1'b1;
        look("rmem.if", c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look("rmem.id", c_ST_ID, c_SB_NONE); adv();
        look("rmem.ex", c_ST_EX, c_SB_NONE); adv();
        look("rmem.mem", c_ST_MEM, c_SB_WR);
        #1 rst = 1'b1;
        #1;
        chk("rmem.dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rmem.state", {29'd0, state}, 32'd0);
        adv();
        rst = 1'b0;
        look("rmem.after", c_ST_IF, c_SB_FETCH); adv();

        // Illegal opcode 0x7F -> ERR from ID
        inst = 32'h0000_007F; mem_ready = 1'b1;
        look("ill.if", c_ST_IF, c_SB_FLOAD); adv();
        mem_ready = 1'b0;
        look("ill.id", c_ST_ID, c_SB_NONE); adv();
        look("ill.err", c_ST_ERR, c_SB_NONE);
        chk("ill.bus_err", {31'd0, bus_err}, 32'd1);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
